// File: rtl/myfilter_pkg.sv
// Shared definitions for the filter unit and its host-side serial master.
package myfilter_pkg;

    localparam int DATABITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        WSHIFT,
        DLOAD,
        ULOAD,
        RSHIFT,
        RESP
    } sm_master_t;

endpackage

// File: rtl/serial_shreg.sv
// Shift register with parallel load; shifts toward the MSB, taking new bits at the LSB.
module serial_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_in,
    output logic [WIDTH-1:0] q
);

    // NOTE: datapath storage is left unreset; it is always reloaded or fully shifted before any bit reaches an output.
    always_ff @(posedge clk) begin
        if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], shift_in};
        end
    end

endmodule

// File: rtl/filter_serial_master.sv
// Host-side master of the filter serial coefficient port: writes shift out then pulse dl,
// reads pulse ul then shift the filter's word back in.
module filter_serial_master
    import myfilter_pkg::*;
#(
    parameter int DATABITS = myfilter_pkg::DATABITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid_in,
    output logic                cmd_ready_out,
    input  logic                cmd_write_in,
    input  logic [DATABITS-1:0] cmd_data_in,
    output logic                rsp_valid_out,
    input  logic                rsp_ready_in,
    output logic [DATABITS-1:0] rsp_data_out,
    output logic                busy_out,
    output logic                sde_out,
    output logic                sd_out,
    input  logic                sd_in,
    output logic                dl_out,
    output logic                ul_out
);

    localparam int CW = $clog2(DATABITS + 1);
    localparam logic [CW-1:0] LAST = CW'(DATABITS - 1);

    sm_master_t          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ready_d, busy_d, sde_d, sd_d, dl_d, ul_d, rsp_valid_d;
    logic [DATABITS-1:0] rsp_data_d;
    logic                sr_load, sr_shift;
    logic [DATABITS-1:0] sr_q;

    // Loaded pre-shifted by one: the MSB leaves directly from cmd_data_in on acceptance.
    serial_shreg #(.WIDTH(DATABITS)) u_shreg (
        .clk       (clk),
        .load      (sr_load),
        .shift     (sr_shift),
        .load_data ({cmd_data_in[DATABITS-2:0], 1'b0}),
        .shift_in  (sd_in),
        .q         (sr_q)
    );

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sde_d       = 1'b0;
        sd_d        = 1'b0;
        dl_d        = 1'b0;
        ul_d        = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_out;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_in && cmd_ready_out) begin
                    cnt_d = '0;
                    if (cmd_write_in) begin
                        state_d = WSHIFT;
                        sr_load = 1'b1;
                        sde_d   = 1'b1;
                        sd_d    = cmd_data_in[DATABITS-1];
                    end else begin
                        state_d = ULOAD;
                        ul_d    = 1'b1;
                    end
                end
            end
            WSHIFT: begin
                sr_shift = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DLOAD;
                    dl_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    sde_d = 1'b1;
                    sd_d  = sr_q[DATABITS-1];
                end
            end
            DLOAD: state_d = IDLE;
            ULOAD: begin
                state_d = RSHIFT;
                cnt_d   = '0;
                sde_d   = 1'b1;
            end
            RSHIFT: begin
                sr_shift = 1'b1;
                if (cnt_q == LAST) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = {sr_q[DATABITS-2:0], sd_in};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    sde_d = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_in) begin
                    state_d = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered from the next state so they line up with it.
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_ready_out <= 1'b1;
            busy_out      <= 1'b0;
            sde_out       <= 1'b0;
            sd_out        <= 1'b0;
            dl_out        <= 1'b0;
            ul_out        <= 1'b0;
            rsp_valid_out <= 1'b0;
            rsp_data_out  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_out <= ready_d;
            busy_out      <= busy_d;
            sde_out       <= sde_d;
            sd_out        <= sd_d;
            dl_out        <= dl_d;
            ul_out        <= ul_d;
            rsp_valid_out <= rsp_valid_d;
            rsp_data_out  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_filter_serial_master.sv
// Directed bench for filter_serial_master with a behavioural filter on the serial side.
module tb_filter_serial_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid_in, cmd_ready_out, cmd_write_in;
    logic [7:0] cmd_data_in;
    logic       rsp_valid_out, rsp_ready_in;
    logic [7:0] rsp_data_out;
    logic       busy_out, sde_out, sd_out, sd_in, dl_out, ul_out;

    int vectors     = 0;
    int miscompares = 0;
    int dl_count    = 0;
    int overlap_errs = 0;
    logic [7:0] exp_q[$];

    // Filter model: shift register fed by sd_out, dl captures it, ul reloads it from coef.
    logic [7:0] fsr, coef;
    logic       model_load;
    logic [7:0] model_val;

    filter_serial_master #(.DATABITS(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid_in  (cmd_valid_in),
        .cmd_ready_out (cmd_ready_out),
        .cmd_write_in  (cmd_write_in),
        .cmd_data_in   (cmd_data_in),
        .rsp_valid_out (rsp_valid_out),
        .rsp_ready_in  (rsp_ready_in),
        .rsp_data_out  (rsp_data_out),
        .busy_out      (busy_out),
        .sde_out       (sde_out),
        .sd_out        (sd_out),
        .sd_in         (sd_in),
        .dl_out        (dl_out),
        .ul_out        (ul_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (model_load)  coef <= model_val;
        else if (dl_out) coef <= fsr;
        if (ul_out)       fsr <= coef;
        else if (sde_out) fsr <= {fsr[6:0], sd_out};
    end
    assign sd_in = fsr[7];

    always @(negedge clk) begin
        if (dl_out) dl_count++;
        if ((dl_out && ul_out) || (dl_out && sde_out) || (ul_out && sde_out)) overlap_errs++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [7:0] d);
        int n = 0;
        while (!cmd_ready_out && n < 50) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", cmd_ready_out, 1);
        cmd_valid_in = 1'b1;
        cmd_write_in = wr;
        cmd_data_in  = d;
        tick();
        cmd_valid_in = 1'b0;
        cmd_data_in  = 8'h00;
    endtask

    // Returns in cycle T+10, with ready already checked high.
    task automatic write_checked(input logic [7:0] d);
        send_cmd(1'b1, d);
        for (int k = 0; k < 8; k++) begin
            check("wr_sde", sde_out, 1);
            check("wr_sd", sd_out, d[7-k]);
            check("wr_dl_low", dl_out, 0);
            check("wr_busy", busy_out, 1);
            tick();
        end
        check("wr_sde_end", sde_out, 0);
        check("wr_dl_pulse", dl_out, 1);
        check("wr_ready_low", cmd_ready_out, 0);
        tick();
        check("wr_dl_one_cycle", dl_out, 0);
        check("wr_ready_back", cmd_ready_out, 1);
        check("wr_busy_end", busy_out, 0);
        check("wr_coef", coef, d);
    endtask

    // Returns in cycle T+10 with the response presented and not yet accepted.
    task automatic read_checked(input logic [7:0] exp);
        logic [7:0] e;
        exp_q.push_back(exp);
        send_cmd(1'b0, 8'h00);
        check("rd_ul", ul_out, 1);
        check("rd_sde_low", sde_out, 0);
        check("rd_busy", busy_out, 1);
        tick();
        for (int k = 0; k < 8; k++) begin
            check("rd_sde", sde_out, 1);
            check("rd_ul_low", ul_out, 0);
            check("rd_sd_zero", sd_out, 0);
            check("rd_rsp_early", rsp_valid_out, 0);
            tick();
        end
        check("rd_sde_end", sde_out, 0);
        check("rd_rsp_valid", rsp_valid_out, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd_rsp_data", rsp_data_out, e);
        end else begin
            check("rd_queue_empty", 1, 0);
        end
    endtask

    initial begin
        int dl_before;
        rst = 1'b1;
        cmd_valid_in = 1'b0;
        cmd_write_in = 1'b0;
        cmd_data_in  = 8'h00;
        rsp_ready_in = 1'b0;
        model_load   = 1'b0;
        model_val    = 8'h00;

        repeat (2) tick();
        check("rst_ready", cmd_ready_out, 1);
        check("rst_sde", sde_out, 0);
        check("rst_sd", sd_out, 0);
        check("rst_dl", dl_out, 0);
        check("rst_ul", ul_out, 0);
        check("rst_rsp_valid", rsp_valid_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_rsp_data", rsp_data_out, 0);
        rst = 1'b0;
        tick();

        write_checked(8'hA5);

        model_load = 1'b1;
        model_val  = 8'h3C;
        tick();
        model_load = 1'b0;
        read_checked(8'h3C);

        // Hold off the response while a write is offered; it must be ignored.
        cmd_valid_in = 1'b1;
        cmd_write_in = 1'b1;
        cmd_data_in  = 8'h11;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rsp_valid", rsp_valid_out, 1);
            check("bp_rsp_data", rsp_data_out, 8'h3C);
            check("bp_ready_low", cmd_ready_out, 0);
            check("bp_no_sde", sde_out, 0);
        end
        cmd_valid_in = 1'b0;
        rsp_ready_in = 1'b1;
        tick();
        rsp_ready_in = 1'b0;
        check("hs_rsp_drop", rsp_valid_out, 0);
        check("hs_ready", cmd_ready_out, 1);
        check("hs_busy", busy_out, 0);
        check("hs_no_sde", sde_out, 0);

        write_checked(8'hFF);
        read_checked(8'hFF);
        rsp_ready_in = 1'b1;
        tick();
        rsp_ready_in = 1'b0;
        check("lb_rsp_drop", rsp_valid_out, 0);

        // Reset during the 4th serial cycle of a write.
        dl_before = dl_count;
        send_cmd(1'b1, 8'h5A);
        repeat (3) tick();
        check("mid_sde_active", sde_out, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_sde_drop", sde_out, 0);
        check("mid_dl", dl_out, 0);
        check("mid_ready", cmd_ready_out, 1);
        check("mid_busy", busy_out, 0);
        repeat (12) tick();
        check("mid_no_dl_pulse", dl_count, dl_before);
        check("mid_idle_sde", sde_out, 0);
        check("mid_idle_ready", cmd_ready_out, 1);

        check("no_overlap", overlap_errs, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
